// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host transmitter: byte FIFO feeding an 11-bit frame serializer.
// Define PS2_INHIBIT_EN to build host-inhibit detection with abort and retransmit.
module ps2_device_tx #(
  parameter int HALF_CYC = 2000,
  parameter int GAP_CYC  = 5000,
  parameter int FIFO_AW  = 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  input  logic       ps2_clk_in,
  output logic       frame_sent,
  output logic       busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int MAXC  = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int CW    = $clog2(MAXC + 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CW-1:0]    HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, BIT_HI, BIT_LO, GAP
`ifdef PS2_INHIBIT_EN
    , INHIBIT
`endif
  } stateT;

  stateT state;
  logic [7:0]         fifoMem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         head;
  logic [10:0]        shiftReg;
  logic [3:0]         bitCnt;
  logic [CW-1:0]      cycCnt;
  logic               push;
  logic               pop;
  logic               canStart;
  logic               hasRetained;
  logic               startFrame;

`ifdef PS2_INHIBIT_EN
  logic          clkSync1;
  logic          clkSync2;
  logic [CW-1:0] highCnt;
  logic          retained;

  // Host must release the clock for GAP_CYC consecutive cycles before we talk.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clkSync1 <= 1'b0;
      clkSync2 <= 1'b0;
      highCnt  <= '0;
    end else begin
      clkSync1 <= ps2_clk_in;
      clkSync2 <= clkSync1;
      if (!clkSync2)
        highCnt <= '0;
      else if (highCnt != CW'(GAP_CYC))
        highCnt <= highCnt + 1'b1;
    end
  end

  assign canStart    = (highCnt == CW'(GAP_CYC));
  assign hasRetained = retained;
`else
  logic unusedClkIn;
  assign unusedClkIn = ps2_clk_in;
  assign canStart    = 1'b1;
  assign hasRetained = 1'b0;
`endif

  assign tx_ready   = (count != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign startFrame = (state == IDLE) && canStart && (hasRetained || (count != '0));
  assign pop        = startFrame && !hasRetained;
  assign head       = fifoMem[rdPtr];
  assign busy       = (state != IDLE) || (count != '0);

  always_ff @(posedge sys_clk) begin
    if (push)
      fifoMem[wrPtr] <= tx_data;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Line drivers follow the state one cycle later, so clock and data stay aligned.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= IDLE;
      shiftReg     <= '0;
      bitCnt       <= '0;
      cycCnt       <= '0;
      frame_sent   <= 1'b0;
      ps2_clk_out  <= 1'b1;
      ps2_data_out <= 1'b1;
`ifdef PS2_INHIBIT_EN
      retained     <= 1'b0;
`endif
    end else begin
      frame_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (startFrame) begin
            if (!hasRetained)
              shiftReg <= {1'b1, ~^head, head, 1'b0};
`ifdef PS2_INHIBIT_EN
            retained <= 1'b0;
`endif
            bitCnt <= '0;
            cycCnt <= '0;
            state  <= BIT_HI;
          end
        end
        BIT_HI: begin
`ifdef PS2_INHIBIT_EN
          if (!clkSync2 && (bitCnt <= 4'd9)) begin
            state    <= INHIBIT;
            retained <= 1'b1;
            cycCnt   <= '0;
          end else
`endif
          if (cycCnt == HALF_LAST) begin
            cycCnt <= '0;
            state  <= BIT_LO;
          end else begin
            cycCnt <= cycCnt + 1'b1;
          end
        end
        BIT_LO: begin
          if (cycCnt == HALF_LAST) begin
            cycCnt <= '0;
            if (bitCnt == 4'd10) begin
              state      <= GAP;
              frame_sent <= 1'b1;
            end else begin
              bitCnt <= bitCnt + 4'd1;
              state  <= BIT_HI;
            end
          end else begin
            cycCnt <= cycCnt + 1'b1;
          end
        end
        GAP: begin
          if (cycCnt == GAP_LAST) begin
            cycCnt <= '0;
            state  <= IDLE;
          end else begin
            cycCnt <= cycCnt + 1'b1;
          end
        end
`ifdef PS2_INHIBIT_EN
        INHIBIT: begin
          if (canStart)
            state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase

      case (state)
        BIT_HI: begin
          ps2_clk_out  <= 1'b1;
          ps2_data_out <= shiftReg[bitCnt];
        end
        BIT_LO: begin
          ps2_clk_out  <= 1'b0;
          ps2_data_out <= shiftReg[bitCnt];
        end
        default: begin
          ps2_clk_out  <= 1'b1;
          ps2_data_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Randomized self-checking bench for ps2_device_tx; a line monitor decodes frames
// and each scenario task compares them against a byte-queue reference model.
module tb_ps2_device_tx;

  localparam int HALF      = 4;
  localparam int GAPC      = 10;
  localparam int FRAME_CYC = 22 * HALF;

  logic       sys_clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_out;
  logic       ps2_data_out;
  logic       ps2_clk_in;
  logic       frame_sent;
  logic       busy;

  ps2_device_tx #(.HALF_CYC(HALF), .GAP_CYC(GAPC), .FIFO_AW(2)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_out (ps2_clk_out),
    .ps2_data_out(ps2_data_out),
    .ps2_clk_in  (ps2_clk_in),
    .frame_sent  (frame_sent),
    .busy        (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [10:0] bits;
    int          dur;
    int          gap;
  } frameT;

  frameT      frames[$];
  logic [7:0] expQ[$];
  int total = 0;
  int bad   = 0;

  int          hiRun, idleRun, cyc, nBits, sentCnt, fallCnt, abortCnt, gapBefore;
  logic        prevClk;
  logic [10:0] bitsV;
  bit          inFrame;

  // Reference frame: start 0, data LSB first, parity making the 1-count odd, stop 1.
  function automatic logic [10:0] expBits(input logic [7:0] b);
    logic [10:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i + 1] = b[i];
    v[9]  = (($countones(b) % 2) == 0);
    v[10] = 1'b1;
    return v;
  endfunction

  // Line monitor: decodes bits at falling edges of the driven clock.
  initial begin
    hiRun = 0; idleRun = 0; cyc = 0; nBits = 0; sentCnt = 0; fallCnt = 0;
    abortCnt = 0; gapBefore = 0; prevClk = 1'b1; bitsV = '0; inFrame = 0;
    forever begin
      @(negedge sys_clk);
      if (reset) begin
        inFrame = 0; hiRun = 0; idleRun = 0; prevClk = 1'b1;
      end else begin
        if (frame_sent) sentCnt++;
        if (prevClk && !ps2_clk_out) fallCnt++;
        hiRun = ps2_clk_out ? hiRun + 1 : 0;
        if (!inFrame) begin
          if (ps2_clk_out && !ps2_data_out) begin
            inFrame = 1; cyc = 1; nBits = 0; bitsV = '0;
            gapBefore = idleRun; idleRun = 0; hiRun = 1;
          end else if (ps2_clk_out && ps2_data_out) begin
            idleRun++;
          end else begin
            idleRun = 0;
          end
        end else begin
          if (prevClk && !ps2_clk_out) begin
            if (nBits < 11) bitsV[nBits] = ps2_data_out;
            nBits++;
          end
          if (nBits >= 11 && ps2_clk_out) begin
            frames.push_back('{bits: bitsV, dur: cyc, gap: gapBefore});
            inFrame = 0; idleRun = 1;
          end else if (hiRun > HALF + 1) begin
            abortCnt++; inFrame = 0; idleRun = hiRun;
          end else begin
            cyc++;
          end
        end
        prevClk = ps2_clk_out;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    @(negedge sys_clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && k < 1000) begin @(negedge sys_clk); k++; end
    total++;
    if (!tx_ready) begin
      bad++;
      $display("FAIL push_timeout: tx_ready got %b want 1", tx_ready);
    end else begin
      expQ.push_back(b);
    end
    @(negedge sys_clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k = 0;
    while (frames.size() < n && k < budget) begin @(negedge sys_clk); k++; end
    ok = (frames.size() >= n);
  endtask

  task automatic idle_wait();
    int k = 0;
    while ((busy || inFrame) && k < 3000) begin @(negedge sys_clk); k++; end
    repeat (GAPC + 5) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    total++; if (ps2_clk_out !== 1'b1) begin bad++; $display("FAIL reset_clk: got %b want 1", ps2_clk_out); end
    total++; if (ps2_data_out !== 1'b1) begin bad++; $display("FAIL reset_data: got %b want 1", ps2_data_out); end
    total++; if (frame_sent !== 1'b0) begin bad++; $display("FAIL reset_sent: got %b want 0", frame_sent); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    $display("reset: clk=%b data=%b busy=%b ready=%b", ps2_clk_out, ps2_data_out, busy, tx_ready);
  endtask

  task automatic test_single();
    logic [10:0] specBits;
    frameT f;
    bit ok;
    int sent0;
    specBits = 11'b100_0011_1000;
    sent0 = sentCnt;
    push_byte(8'h1C);
    total++; if (ps2_data_out !== 1'b1) begin bad++; $display("FAIL latency_t1: data got %b want 1", ps2_data_out); end
    @(negedge sys_clk);
    total++; if (ps2_data_out !== 1'b1) begin bad++; $display("FAIL latency_t2: data got %b want 1", ps2_data_out); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge sys_clk);
    total++; if (ps2_data_out !== 1'b0) begin bad++; $display("FAIL latency_t3: data got %b want 0", ps2_data_out); end
    wait_frames(1, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: frames got %0d want 1", frames.size()); end
    if (ok) begin
      f = frames.pop_front();
      void'(expQ.pop_front());
      total++; if (f.bits !== specBits) begin bad++; $display("FAIL single_bits: got %03h want %03h", f.bits, specBits); end
      total++; if (f.bits !== expBits(8'h1C)) begin bad++; $display("FAIL single_model: got %03h want %03h", f.bits, expBits(8'h1C)); end
      total++; if (f.dur !== FRAME_CYC) begin bad++; $display("FAIL single_dur: got %0d want %0d", f.dur, FRAME_CYC); end
      $display("single: byte=1c bits=%03h dur=%0d", f.bits, f.dur);
    end
    idle_wait();
    total++; if (sentCnt - sent0 !== 1) begin bad++; $display("FAIL single_sent: got %0d want 1", sentCnt - sent0); end
  endtask

  task automatic test_back_to_back();
    frameT f;
    logic [7:0] e;
    bit ok;
    int idx = 0;
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(2, 600, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: frames got %0d want 2", frames.size()); end
    while (frames.size() > 0 && expQ.size() > 0) begin
      f = frames.pop_front();
      e = expQ.pop_front();
      total++; if (f.bits !== expBits(e)) begin bad++; $display("FAIL b2b_bits: got %03h want %03h", f.bits, expBits(e)); end
      total++; if (f.bits[9] !== 1'b1) begin bad++; $display("FAIL b2b_parity: got %b want 1", f.bits[9]); end
      if (idx == 1) begin
        total++;
        if (f.gap < GAPC || f.gap > GAPC + 2) begin bad++; $display("FAIL b2b_gap: got %0d want %0d..%0d", f.gap, GAPC, GAPC + 2); end
      end
      $display("b2b: byte=%02h bits=%03h gap=%0d", e, f.bits, f.gap);
      idx++;
    end
    idle_wait();
  endtask

  task automatic test_fifo_full();
    frameT f;
    logic [7:0] e;
    bit ok;
    int acc = 0, accAtDrop = -1, k = 0;
    push_byte(8'($urandom_range(255)));
    repeat (10) @(negedge sys_clk);
    tx_valid = 1'b1;
    while (acc < 6 && k < 3000) begin
      tx_data = 8'(acc + 1);
      if (tx_ready) begin
        expQ.push_back(8'(acc + 1));
        acc++;
      end else if (accAtDrop < 0) begin
        accAtDrop = acc;
      end
      @(negedge sys_clk);
      k++;
    end
    tx_valid = 1'b0;
    total++; if (accAtDrop !== 4) begin bad++; $display("FAIL full_drop: queued got %0d want 4", accAtDrop); end
    total++; if (acc !== 6) begin bad++; $display("FAIL full_accept: got %0d want 6", acc); end
    wait_frames(7, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout: frames got %0d want 7", frames.size()); end
    while (frames.size() > 0 && expQ.size() > 0) begin
      f = frames.pop_front();
      e = expQ.pop_front();
      total++; if (f.bits !== expBits(e)) begin bad++; $display("FAIL full_order: got %03h want %03h", f.bits, expBits(e)); end
      $display("full: byte=%02h bits=%03h", e, f.bits);
    end
    idle_wait();
  endtask

  task automatic test_random();
    frameT f;
    logic [7:0] e;
    bit ok;
    int sent0 = sentCnt;
    for (int i = 0; i < 10; i++) begin
      push_byte(8'($urandom_range(255)));
      repeat ($urandom_range(150)) @(negedge sys_clk);
    end
    wait_frames(10, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_timeout: frames got %0d want 10", frames.size()); end
    while (frames.size() > 0 && expQ.size() > 0) begin
      f = frames.pop_front();
      e = expQ.pop_front();
      total++; if (f.bits !== expBits(e)) begin bad++; $display("FAIL rand_bits: got %03h want %03h", f.bits, expBits(e)); end
      total++; if (f.dur !== FRAME_CYC) begin bad++; $display("FAIL rand_dur: got %0d want %0d", f.dur, FRAME_CYC); end
      total++; if (f.gap < GAPC) begin bad++; $display("FAIL rand_gap: got %0d want >=%0d", f.gap, GAPC); end
      $display("rand: byte=%02h bits=%03h dur=%0d gap=%0d", e, f.bits, f.dur, f.gap);
    end
    idle_wait();
    total++; if (sentCnt - sent0 !== 10) begin bad++; $display("FAIL rand_sent: got %0d want 10", sentCnt - sent0); end
  endtask

`ifndef PS2_INHIBIT_EN
  task automatic test_ignore_clk_in();
    frameT f;
    bit ok;
    int sent0 = sentCnt;
    ps2_clk_in = 1'b0;
    push_byte(8'h5A);
    wait_frames(1, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL noinh_timeout: frames got %0d want 1", frames.size()); end
    if (ok) begin
      f = frames.pop_front();
      void'(expQ.pop_front());
      total++; if (f.bits !== expBits(8'h5A)) begin bad++; $display("FAIL noinh_bits: got %03h want %03h", f.bits, expBits(8'h5A)); end
      total++; if (f.dur !== FRAME_CYC) begin bad++; $display("FAIL noinh_dur: got %0d want %0d", f.dur, FRAME_CYC); end
      $display("noinh: byte=5a bits=%03h dur=%0d", f.bits, f.dur);
    end
    idle_wait();
    total++; if (sentCnt - sent0 !== 1) begin bad++; $display("FAIL noinh_sent: got %0d want 1", sentCnt - sent0); end
    ps2_clk_in = 1'b1;
  endtask
`else
  task automatic test_inhibit();
    frameT f;
    bit ok;
    bit released = 0;
    logic [7:0] b;
    int sent0 = sentCnt, abort0 = abortCnt, k = 0;
    b = 8'($urandom_range(255));
    push_byte(b);
    while (!(inFrame && nBits == 5 && ps2_clk_out) && k < 500) begin @(negedge sys_clk); k++; end
    ps2_clk_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (i >= 3 && i < 8 && ps2_clk_out && ps2_data_out) released = 1;
    end
    total++; if (!released) begin bad++; $display("FAIL inh_release: lines not released, clk=%b data=%b", ps2_clk_out, ps2_data_out); end
    total++; if (sentCnt !== sent0) begin bad++; $display("FAIL inh_sent: got %0d want %0d", sentCnt, sent0); end
    ps2_clk_in = 1'b1;
    wait_frames(1, 600, ok);
    total++; if (!ok) begin bad++; $display("FAIL inh_timeout: frames got %0d want 1", frames.size()); end
    total++; if (abortCnt - abort0 !== 1) begin bad++; $display("FAIL inh_abort: got %0d want 1", abortCnt - abort0); end
    if (ok) begin
      f = frames.pop_front();
      void'(expQ.pop_front());
      total++; if (f.bits !== expBits(b)) begin bad++; $display("FAIL inh_resend: got %03h want %03h", f.bits, expBits(b)); end
      $display("inhibit: byte=%02h resent bits=%03h", b, f.bits);
    end
    idle_wait();
    total++; if (sentCnt - sent0 !== 1) begin bad++; $display("FAIL inh_sentafter: got %0d want 1", sentCnt - sent0); end
  endtask
`endif

  task automatic test_reset_midframe();
    int k = 0, fall0, sent0;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(255)));
    while (!inFrame && k < 500) begin @(negedge sys_clk); k++; end
    repeat (30) @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    total++; if (ps2_clk_out !== 1'b1) begin bad++; $display("FAIL midrst_clk: got %b want 1", ps2_clk_out); end
    total++; if (ps2_data_out !== 1'b1) begin bad++; $display("FAIL midrst_data: got %b want 1", ps2_data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", tx_ready); end
    reset = 1'b0;
    expQ.delete();
    fall0 = fallCnt;
    sent0 = sentCnt;
    repeat (300) @(negedge sys_clk);
    total++; if (fallCnt !== fall0) begin bad++; $display("FAIL midrst_edges: got %0d want %0d", fallCnt, fall0); end
    total++; if (sentCnt !== sent0) begin bad++; $display("FAIL midrst_sent: got %0d want %0d", sentCnt, sent0); end
    total++; if (frames.size() !== 0) begin bad++; $display("FAIL midrst_frames: got %0d want 0", frames.size()); end
    $display("midreset: clk=%b data=%b busy=%b edges=%0d", ps2_clk_out, ps2_data_out, busy, fallCnt - fall0);
  endtask

  initial begin
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    ps2_clk_in = 1'b1;
    reset      = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    test_reset();
    repeat (20) @(negedge sys_clk);
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_random();
`ifndef PS2_INHIBIT_EN
    test_ignore_clk_in();
`else
    test_inhibit();
`endif
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 SHALL have parameter HALF_CYC, default 2000: sys_clk cycles per PS/2 clock half-period (12.5 kHz at 50 MHz).
REQ-002 SHALL have parameter GAP_CYC, default 5000: idle sys_clk cycles after each frame.
REQ-003 SHALL have parameter FIFO_AW, default 2: log2 of FIFO depth (4 bytes).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 sys_clk  in  1  single clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 tx_data  in  8  scancode byte to send.
REQ-008 tx_valid  in  1  tx_data valid.
REQ-009 tx_ready  out  1  FIFO not full; a byte is accepted on a sys_clk edge with tx_valid&tx_ready.
REQ-010 ps2_clk_out  out  1  PS/2 clock drive: 0 = pull low, 1 = release.
REQ-011 ps2_data_out  out  1  PS/2 data drive: 0 = pull low, 1 = release.
REQ-012 ps2_clk_in  in  1  sensed PS/2 clock line, asynchronous.
REQ-013 frame_sent  out  1  one-cycle pulse per completed frame.
REQ-014 busy  out  1  high when the state is not IDLE or the FIFO is non-empty.

Function
REQ-015 SHALL buffer accepted bytes in a FIFO_AW-addressed FIFO and transmit them in order; tx_ready = !full, combinational from the FIFO count.
REQ-016 Frame SHALL be 11 bits: start 0, data LSB first, odd parity (~^data), stop 1.
REQ-017 FSM states SHALL be IDLE, BIT_HI, BIT_LO, GAP, INHIBIT.
REQ-018 IDLE: if the FIFO is non-empty (and not inhibited, REQ-026), pop the head into the shift register, set bit count = 0, and go to BIT_HI.
REQ-019 BIT_HI: ps2_clk_out=1 and ps2_data_out=current bit for HALF_CYC cycles, then go to BIT_LO.
REQ-020 BIT_LO: ps2_clk_out=0 and data held for HALF_CYC cycles; then go to GAP if bit count = 10, else increment the count and go to BIT_HI.
REQ-021 Data SHALL change only while ps2_clk_out=1; the falling clock edge SHALL be mid-bit.
REQ-022 GAP: both lines = 1 for GAP_CYC cycles, then go to IDLE; frame_sent SHALL pulse on the GAP entry cycle.
REQ-023 Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge t SHALL drive ps2_data_out=0 from edge t+2.
REQ-024 A frame SHALL occupy exactly 22*HALF_CYC cycles, and consecutive frames SHALL be separated by at least GAP_CYC cycles.
REQ-025 A push and a pop in the same cycle SHALL leave the count unchanged. A push while full is impossible because tx_ready=0. The pointers SHALL wrap modulo 2^FIFO_AW.

Reset
REQ-026 On reset: ps2_clk_out=1, ps2_data_out=1, frame_sent=0, busy=0, FIFO emptied, state IDLE, counters 0, retained byte cleared; tx_ready=1 from the first cycle after reset.
REQ-027 Reset mid-frame SHALL abort the frame, release both lines on the next edge, and discard the in-flight byte with no frame_sent.

Configuration
REQ-028 Macro PS2_INHIBIT_EN SHALL enable host-inhibit handling.
REQ-029 With PS2_INHIBIT_EN: ps2_clk_in passes through a 2-FF synchronizer. A synchronized low seen during BIT_HI with bit count ≤ 9 SHALL do the following: go to INHIBIT; release both lines; retain the byte; suppress frame_sent.
REQ-030 INHIBIT and IDLE with PS2_INHIBIT_EN: stay until ps2_clk_in has been high for GAP_CYC consecutive cycles. After an abort, retransmit the retained byte ahead of the FIFO head. IDLE SHALL NOT start a frame while the synchronized clock is low.
REQ-031 Without PS2_INHIBIT_EN: ps2_clk_in is ignored; the INHIBIT state and the synchronizer are not built; frames never abort.

Verification (HALF_CYC=4, GAP_CYC=10)
REQ-032 Push 0x1C while idle -> bits sampled at ps2_clk_out falling edges = 0,0,0,1,1,1,0,0,0,0,1; frame lasts 88 cycles; one frame_sent pulse.
REQ-033 Push 0x00 then 0xFF back-to-back -> parity bit 1 in both frames; 10 idle-high cycles between the frames.
REQ-034 Hold tx_valid with 0x01..0x06 during a frame -> tx_ready drops once 4 bytes are queued; all 6 bytes are sent in order with none lost.
REQ-035 PS2_INHIBIT_EN on, ps2_clk_in low for 20 cycles during bit 5 BIT_HI -> both lines released within 3 cycles, no frame_sent; the same byte is fully resent after 10 high cycles.
REQ-036 Reset asserted mid-frame with 2 bytes queued -> both outputs 1, busy=0, tx_ready=1; no further ps2_clk_out edges.
REQ-037 PS2_INHIBIT_EN off, ps2_clk_in tied low, push 0x5A -> normal 88-cycle frame and a frame_sent pulse.
